// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two writers.
// Define RFARB_ZERO_DROP_EN to suppress the write enable for commands targeting register 0.
module regfile_wr_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic [ADDR_W-1:0] Rw,
  output logic [DATA_W-1:0] busW,
  output logic              wrEn,
  output logic              grant_id
);

  logic              slot0Full, slot1Full;
  logic [ADDR_W-1:0] slot0Addr, slot1Addr;
  logic [DATA_W-1:0] slot0Data, slot1Data;
  logic              ptr;

  logic              grant0, grant1, grantAny;
  logic              accept0, accept1;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  logic              dropWrite;

  // Arbitration looks only at pre-edge slot state, so a slot filling this edge cannot be granted.
  always_comb begin
    grant0   = slot0Full && (!slot1Full || !ptr);
    grant1   = slot1Full && (!slot0Full || ptr);
    grantAny = grant0 || grant1;
    selAddr  = grant1 ? slot1Addr : slot0Addr;
    selData  = grant1 ? slot1Data : slot0Data;
    req0_ready = !slot0Full || grant0;
    req1_ready = !slot1Full || grant1;
    accept0  = req0_valid && req0_ready;
    accept1  = req1_valid && req1_ready;
  end

`ifdef RFARB_ZERO_DROP_EN
  assign dropWrite = (selAddr == '0);
`else
  assign dropWrite = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0Full <= 1'b0;
      slot1Full <= 1'b0;
      slot0Addr <= '0;
      slot1Addr <= '0;
      slot0Data <= '0;
      slot1Data <= '0;
      ptr       <= 1'b0;
      wrEn      <= 1'b0;
      Rw        <= '0;
      busW      <= '0;
      grant_id  <= 1'b0;
    end else begin
      if (accept0) begin
        slot0Full <= 1'b1;
        slot0Addr <= req0_addr;
        slot0Data <= req0_data;
      end else if (grant0) begin
        slot0Full <= 1'b0;
      end

      if (accept1) begin
        slot1Full <= 1'b1;
        slot1Addr <= req1_addr;
        slot1Data <= req1_data;
      end else if (grant1) begin
        slot1Full <= 1'b0;
      end

      if (grantAny) begin
        wrEn     <= !dropWrite;
        Rw       <= selAddr;
        busW     <= selData;
        grant_id <= grant1;
        ptr      <= !grant1;
      end else begin
        wrEn     <= 1'b0;
      end
    end
  end

endmodule
